rt_budget_sched: RTL

Budget-regulated round-robin scheduler sharing one AXI manager burst slot between `NumMgr` requesters in the Cheshire real-time (AxiRt) path. Each requester gets a beat budget that is reloaded at the start of every regulation period. A request is granted only if the requester's remaining budget covers the burst. Grants go out through a registered valid/ready slot toward the downstream AXI mux.

---
 rtl/rt_budget_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rt_budget_sched.sv
// Budget-regulated round-robin scheduler for one shared AXI burst slot.
// Optional feature: define RT_SCHED_WORK_CONSERVING_EN for work-conserving fallback arbitration.
module rt_budget_sched #(
  parameter int unsigned NumMgr      = 4,
  parameter int unsigned LenWidth    = 8,
  parameter int unsigned BudgetWidth = 16,
  parameter int unsigned PeriodWidth = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   en_i,
  input  logic [PeriodWidth-1:0]                 period_i,
  input  logic [NumMgr-1:0][BudgetWidth-1:0]     budget_i,
  input  logic [NumMgr-1:0]                      req_valid_i,
  input  logic [NumMgr-1:0][LenWidth-1:0]        req_len_i,
  output logic [NumMgr-1:0]                      req_ready_o,
  output logic                                   gnt_valid_o,
  input  logic                                   gnt_ready_i,
  output logic [$clog2(NumMgr)-1:0]              gnt_idx_o,
  output logic [LenWidth-1:0]                    gnt_len_o,
  output logic [NumMgr-1:0][BudgetWidth-1:0]     budget_left_o,
  output logic [PeriodWidth-1:0]                 period_cnt_o,
  output logic [NumMgr-1:0]                      isolated_o
);

  localparam int unsigned IdxWidth  = $clog2(NumMgr);
  localparam int unsigned CostWidth = LenWidth + 1;
  localparam int unsigned CmpWidth  = (BudgetWidth > CostWidth) ? BudgetWidth : CostWidth;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                             state, state_next;
  logic [NumMgr-1:0][BudgetWidth-1:0] budget_left;
  logic [PeriodWidth-1:0]             period_cnt, period_len, period_eff;
  logic [IdxWidth-1:0]                rr_ptr, gnt_idx, sel;
  logic [LenWidth-1:0]                gnt_len;
  logic                               gnt_valid;

  logic [NumMgr-1:0][CostWidth-1:0]   cost;
  logic [NumMgr-1:0]                  eligible, cand, win;
  logic                               found, fallback, accept, wrap;
  logic [CmpWidth-1:0]                charged;
  logic [31:0]                        pos;

  // Cost and eligibility per requester.
  always_comb begin
    for (int i = 0; i < NumMgr; i++) begin
      cost[i]     = CostWidth'(req_len_i[i]) + CostWidth'(1);
      eligible[i] = req_valid_i[i] && (CmpWidth'(budget_left[i]) >= CmpWidth'(cost[i]));
    end
  end

`ifdef RT_SCHED_WORK_CONSERVING_EN
  assign fallback = ~|eligible & |req_valid_i;
  assign cand     = fallback ? req_valid_i : eligible;
`else
  assign fallback = 1'b0;
  assign cand     = eligible;
`endif

  // Round-robin pick starting one past the last granted requester.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    pos   = '0;
    for (int unsigned k = 1; k <= NumMgr; k++) begin
      pos = (32'(rr_ptr) + k) % NumMgr;
      if (!found && cand[pos]) begin
        found = 1'b1;
        sel   = IdxWidth'(pos);
      end
    end
  end

  assign win        = found ? (NumMgr'(1) << sel) : '0;
  // The exit cycle out of RUN (en_i low) never accepts, so nothing lands in the slot behind IDLE.
  assign accept     = (state == StRun) && en_i && (!gnt_valid || gnt_ready_i) && found;
  assign wrap       = (period_cnt == period_len - PeriodWidth'(1));
  assign period_eff = (period_i == '0) ? PeriodWidth'(1) : period_i;
  assign charged    = (CmpWidth'(budget_left[sel]) >= CmpWidth'(cost[sel]))
                    ? CmpWidth'(budget_left[sel]) - CmpWidth'(cost[sel]) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= StIdle;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (en_i) state_next = StRun;
      StRun:   if (!en_i) state_next = gnt_valid ? StDrain : StIdle;
      StDrain: if (!gnt_valid || gnt_ready_i) state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    isolated_o  = '0;
    if (accept) req_ready_o = win;
    if (state == StRun) begin
      isolated_o = req_valid_i & ~eligible;
      if (fallback) isolated_o = req_valid_i & ~eligible & ~win;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      gnt_len   <= '0;
      rr_ptr    <= IdxWidth'(NumMgr - 1);
    end else if (accept) begin
      gnt_valid <= 1'b1;
      gnt_idx   <= sel;
      gnt_len   <= req_len_i[sel];
      rr_ptr    <= sel;
    end else if (gnt_ready_i) begin
      gnt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      budget_left <= '0;
      period_cnt  <= '0;
      period_len  <= PeriodWidth'(1);
    end else if (state == StIdle && en_i) begin
      budget_left <= budget_i;
      period_cnt  <= '0;
      period_len  <= period_eff;
    end else if (state == StRun) begin
      if (wrap) begin
        // Reload wins over a same-cycle charge.
        budget_left <= budget_i;
        period_cnt  <= '0;
        period_len  <= period_eff;
      end else begin
        period_cnt <= period_cnt + PeriodWidth'(1);
        if (accept) budget_left[sel] <= BudgetWidth'(charged);
      end
    end
  end

  assign gnt_valid_o   = gnt_valid;
  assign gnt_idx_o     = gnt_idx;
  assign gnt_len_o     = gnt_len;
  assign budget_left_o = budget_left;
  assign period_cnt_o  = period_cnt;

endmodule
